mem_bus_arbiter: RTL and testbench

- Shares one downstream memory bus between the core's instruction-fetch port and its load/store port.
- Issues one transaction at a time on the bus and tracks it to completion.
- Generates the core's stall_if and stall_mem inputs.
- Discards fetch responses made stale by a PC redirect, and applies a response watchdog.

---
 rtl/mem_bus_arbiter_pkg.sv | 21 ++
 rtl/mem_arb_wdt.sv | 43 ++++
 rtl/mem_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared FSM states, owner codes and defaults for mem_bus_arbiter
// Purpose: constants shared by the arbiter top and its watchdog.
// Ports: none (package).
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_RD   = 2'd2,
      OWN_WR   = 2'd3
   } owner_t;

   localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_arb_wdt.sv
// rtl/mem_arb_wdt.sv - response watchdog down-counter for mem_bus_arbiter
// Purpose: loaded when a transaction enters WAIT, counts down once per WAIT
//          cycle and flags expiry on the TIMEOUT-th WAIT cycle with no response.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - preload TIMEOUT-1 (highest priority)
//   clear     - force count to zero
//   en        - count enable (arbiter is in WAIT)
//   expire    - high while enabled and the count has reached zero
module mem_arb_wdt
   import mem_bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic clear,
   input  logic en,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         // The load cycle is the last REQ cycle, so the first WAIT cycle
         // sees TIMEOUT-1 and expiry lands on the TIMEOUT-th WAIT cycle.
         cnt <= CNT_W'(TIMEOUT - 1);
      end else if (clear) begin
         cnt <= '0;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign expire = en && (cnt == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory bus between fetch and load/store ports
// Purpose: fixed-priority (store > load > fetch) single-outstanding bus
//          arbiter producing core stalls, stale-fetch discard and a watchdog.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   instr_rd_en_i, pc_i              - fetch request / address
//   instr_o, addr_instr_o            - fetched instruction and its address
//   stall_if_o                       - fetch stall
//   mem_rd_en_i, addr_mem_rd_i       - load request / address
//   mem_wr_en_i, addr_mem_wr_i,
//   data_mem_wr_i, strb_mem_wr_i     - store request / address / data / strobes
//   data_mem_o, stall_mem_o          - load data, load/store stall
//   bus_req_o .. bus_strb_o          - downstream request
//   bus_gnt_i, bus_rvalid_i,
//   bus_rdata_i, bus_err_i           - downstream handshake and response
//   err_o                            - one-cycle pulse on bus error or watchdog abort
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int INSTR_W = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                instr_rd_en_i,
   input  logic [ADDR_W-1:0]   pc_i,
   output logic [INSTR_W-1:0]  instr_o,
   output logic [ADDR_W-1:0]   addr_instr_o,
   output logic                stall_if_o,
   input  logic                mem_rd_en_i,
   input  logic [ADDR_W-1:0]   addr_mem_rd_i,
   input  logic                mem_wr_en_i,
   input  logic [ADDR_W-1:0]   addr_mem_wr_i,
   input  logic [DATA_W-1:0]   data_mem_wr_i,
   input  logic [DATA_W/8-1:0] strb_mem_wr_i,
   output logic [DATA_W-1:0]   data_mem_o,
   output logic                stall_mem_o,
   output logic                bus_req_o,
   output logic                bus_we_o,
   output logic [ADDR_W-1:0]   bus_addr_o,
   output logic [DATA_W-1:0]   bus_wdata_o,
   output logic [DATA_W/8-1:0] bus_strb_o,
   input  logic                bus_gnt_i,
   input  logic                bus_rvalid_i,
   input  logic [DATA_W-1:0]   bus_rdata_i,
   input  logic                bus_err_i,
   output logic                err_o
);

   state_t            state;
   owner_t            owner;
   logic              if_done;
   logic              rd_done;
   logic              wr_done;
   logic              wdt_load;
   logic              wdt_clear;
   logic              wdt_en;
   logic              wdt_expire;
   logic              finish;
   logic [DATA_W-1:0] rsp_data;

   assign stall_if_o  = instr_rd_en_i & ~if_done;
   // A load raised alongside a store is ignored, so it must not stall either.
   assign stall_mem_o = (mem_wr_en_i & ~wr_done) | (mem_rd_en_i & ~mem_wr_en_i & ~rd_done);

   assign finish    = (state == ST_WAIT) && (bus_rvalid_i || wdt_expire);
   assign wdt_load  = (state == ST_REQ) && bus_gnt_i;
   assign wdt_en    = (state == ST_WAIT);
   assign wdt_clear = finish;
   // Watchdog aborts return zero data.
   assign rsp_data  = bus_rvalid_i ? bus_rdata_i : '0;

   mem_arb_wdt #(
      .TIMEOUT (TIMEOUT)
   ) u_wdt (
      .clk    (clk),
      .rst    (rst),
      .load   (wdt_load),
      .clear  (wdt_clear),
      .en     (wdt_en),
      .expire (wdt_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         owner        <= OWN_NONE;
         bus_req_o    <= 1'b0;
         bus_we_o     <= 1'b0;
         bus_addr_o   <= '0;
         bus_wdata_o  <= '0;
         bus_strb_o   <= '0;
         err_o        <= 1'b0;
         if_done      <= 1'b0;
         rd_done      <= 1'b0;
         wr_done      <= 1'b0;
         instr_o      <= '0;
         addr_instr_o <= '0;
         data_mem_o   <= '0;
      end else begin
         if_done <= 1'b0;
         rd_done <= 1'b0;
         wr_done <= 1'b0;
         err_o   <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Done flags mask their requester so the hand-back cycle
               // cannot re-issue the transaction that just completed.
               if (mem_wr_en_i && !wr_done) begin
                  owner       <= OWN_WR;
                  state       <= ST_REQ;
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= 1'b1;
                  bus_addr_o  <= addr_mem_wr_i;
                  bus_wdata_o <= data_mem_wr_i;
                  bus_strb_o  <= strb_mem_wr_i;
               end else if (mem_rd_en_i && !mem_wr_en_i && !rd_done) begin
                  owner       <= OWN_RD;
                  state       <= ST_REQ;
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= 1'b0;
                  bus_addr_o  <= addr_mem_rd_i;
                  bus_wdata_o <= '0;
                  bus_strb_o  <= '0;
               end else if (instr_rd_en_i && !if_done) begin
                  owner       <= OWN_IF;
                  state       <= ST_REQ;
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= 1'b0;
                  bus_addr_o  <= pc_i;
                  bus_wdata_o <= '0;
                  bus_strb_o  <= '0;
               end
            end
            ST_REQ: begin
               if (bus_gnt_i) begin
                  bus_req_o <= 1'b0;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (finish) begin
                  state <= ST_IDLE;
                  owner <= OWN_NONE;
                  err_o <= bus_rvalid_i ? bus_err_i : 1'b1;
                  case (owner)
                     OWN_WR: wr_done <= 1'b1;
                     OWN_RD: begin
                        rd_done    <= 1'b1;
                        data_mem_o <= rsp_data;
                     end
                     OWN_IF: begin
                        // bus_addr_o still holds the fetch address; a PC
                        // redirect since issue makes this response stale.
                        if (bus_addr_o == pc_i) begin
                           if_done      <= 1'b1;
                           instr_o      <= rsp_data[INSTR_W-1:0];
                           addr_instr_o <= bus_addr_o;
                        end
                     end
                     default: begin
                     end
                  endcase
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

   localparam int ADDR_W  = 64;
   localparam int DATA_W  = 64;
   localparam int INSTR_W = 32;
   localparam int TIMEOUT = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                instr_rd_en_i;
   logic [ADDR_W-1:0]   pc_i;
   logic [INSTR_W-1:0]  instr_o;
   logic [ADDR_W-1:0]   addr_instr_o;
   logic                stall_if_o;
   logic                mem_rd_en_i;
   logic [ADDR_W-1:0]   addr_mem_rd_i;
   logic                mem_wr_en_i;
   logic [ADDR_W-1:0]   addr_mem_wr_i;
   logic [DATA_W-1:0]   data_mem_wr_i;
   logic [DATA_W/8-1:0] strb_mem_wr_i;
   logic [DATA_W-1:0]   data_mem_o;
   logic                stall_mem_o;
   logic                bus_req_o;
   logic                bus_we_o;
   logic [ADDR_W-1:0]   bus_addr_o;
   logic [DATA_W-1:0]   bus_wdata_o;
   logic [DATA_W/8-1:0] bus_strb_o;
   logic                bus_gnt_i;
   logic                bus_rvalid_i;
   logic [DATA_W-1:0]   bus_rdata_i;
   logic                bus_err_i;
   logic                err_o;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .INSTR_W (INSTR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .instr_rd_en_i (instr_rd_en_i),
      .pc_i          (pc_i),
      .instr_o       (instr_o),
      .addr_instr_o  (addr_instr_o),
      .stall_if_o    (stall_if_o),
      .mem_rd_en_i   (mem_rd_en_i),
      .addr_mem_rd_i (addr_mem_rd_i),
      .mem_wr_en_i   (mem_wr_en_i),
      .addr_mem_wr_i (addr_mem_wr_i),
      .data_mem_wr_i (data_mem_wr_i),
      .strb_mem_wr_i (strb_mem_wr_i),
      .data_mem_o    (data_mem_o),
      .stall_mem_o   (stall_mem_o),
      .bus_req_o     (bus_req_o),
      .bus_we_o      (bus_we_o),
      .bus_addr_o    (bus_addr_o),
      .bus_wdata_o   (bus_wdata_o),
      .bus_strb_o    (bus_strb_o),
      .bus_gnt_i     (bus_gnt_i),
      .bus_rvalid_i  (bus_rvalid_i),
      .bus_rdata_i   (bus_rdata_i),
      .bus_err_i     (bus_err_i),
      .err_o         (err_o)
   );

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  strb;
   } txn_t;

   txn_t        exp_q[$];
   int          checks    = 0;
   int          failures  = 0;
   int          gnt_delay = 0;
   int          rsp_wait  = 0;
   logic        rsp_err   = 1'b0;
   logic [63:0] rsp_base  = 64'h0123_4567_8000_0013;
   logic        pending   = 1'b0;
   int          req_cnt   = 0;
   int          wait_cnt  = 0;
   int          hs_count  = 0;
   logic [63:0] rsp_addr  = '0;

   function automatic logic [63:0] rsp_of(input logic [63:0] base, input logic [63:0] a);
      return base ^ {32'h0, a[31:0]};
   endfunction

   function automatic txn_t mk(input logic we, input logic [63:0] a,
                               input logic [63:0] d, input logic [7:0] s);
      txn_t t;
      t.we = we; t.addr = a; t.wdata = d; t.strb = s;
      return t;
   endfunction

   // Bus slave: grants after gnt_delay REQ cycles, answers rsp_wait WAIT
   // cycles after the handshake (never when negative), and scoreboards
   // every accepted request against exp_q.
   initial begin
      txn_t e;
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0; bus_err_i = 1'b0;
      forever begin
         @(negedge clk);
         bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
         if (pending) begin
            if (rsp_wait >= 0 && wait_cnt >= rsp_wait) begin
               bus_rvalid_i = 1'b1;
               bus_rdata_i  = rsp_of(rsp_base, rsp_addr);
               bus_err_i    = rsp_err;
               pending      = 1'b0;
            end else begin
               wait_cnt++;
            end
         end else if (bus_req_o === 1'b1) begin
            if (req_cnt >= gnt_delay) begin
               bus_gnt_i = 1'b1;
               req_cnt   = 0;
               pending   = 1'b1;
               wait_cnt  = 0;
               hs_count++;
               rsp_addr  = bus_addr_o;
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL bus_txn unexpected request got we=%b addr=%h required none", bus_we_o, bus_addr_o);
               end else begin
                  e = exp_q.pop_front();
                  if (bus_we_o !== e.we || bus_addr_o !== e.addr ||
                      (e.we && (bus_wdata_o !== e.wdata || bus_strb_o !== e.strb))) begin
                     failures++;
                     $display("FAIL bus_txn got we=%b addr=%h wdata=%h strb=%h required we=%b addr=%h wdata=%h strb=%h",
                              bus_we_o, bus_addr_o, bus_wdata_o, bus_strb_o, e.we, e.addr, e.wdata, e.strb);
                  end
               end
            end else begin
               req_cnt++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      instr_rd_en_i = 1'b0; pc_i = '0;
      mem_rd_en_i = 1'b0; addr_mem_rd_i = '0;
      mem_wr_en_i = 1'b0; addr_mem_wr_i = '0; data_mem_wr_i = '0; strb_mem_wr_i = '0;
      repeat (3) step();
      checks++;
      if (bus_req_o !== 1'b0 || bus_we_o !== 1'b0 || err_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl got req=%b we=%b err=%b required 0 0 0", bus_req_o, bus_we_o, err_o);
      end
      checks++;
      if (instr_o !== '0 || addr_instr_o !== '0 || data_mem_o !== '0 ||
          bus_addr_o !== '0 || bus_wdata_o !== '0 || bus_strb_o !== '0) begin
         failures++;
         $display("FAIL reset_data got instr=%h addr_instr=%h data=%h baddr=%h wdata=%h strb=%h required all 0",
                  instr_o, addr_instr_o, data_mem_o, bus_addr_o, bus_wdata_o, bus_strb_o);
      end
      checks++;
      if (stall_if_o !== 1'b0 || stall_mem_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_stall got if=%b mem=%b required 0 0", stall_if_o, stall_mem_o);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_fetch();
      int hs0;
      logic [63:0] exp_d;
      hs0   = hs_count;
      exp_d = rsp_of(rsp_base, 64'h8000_0000);
      exp_q.push_back(mk(1'b0, 64'h8000_0000, '0, '0));
      instr_rd_en_i = 1'b1; pc_i = 64'h8000_0000;
      #1;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) step();
         checks++;
         if (stall_if_o !== (c < 3)) begin
            failures++;
            $display("FAIL fetch_stall cycle %0d got %b required %b", c, stall_if_o, (c < 3));
         end
      end
      checks++;
      if (instr_o !== 32'h0000_0013 || instr_o !== exp_d[31:0] || addr_instr_o !== 64'h8000_0000) begin
         failures++;
         $display("FAIL fetch_data got instr=%h addr=%h required 00000013 0000000080000000", instr_o, addr_instr_o);
      end
      instr_rd_en_i = 1'b0;
      repeat (3) step();
      checks++;
      if (hs_count - hs0 !== 1 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL fetch_handshakes got %0d required 1", hs_count - hs0);
      end
   endtask

   task automatic test_store_priority();
      int wr_cyc, if_cyc;
      logic first_req;
      wr_cyc = -1; if_cyc = -1; first_req = 1'b0;
      exp_q.push_back(mk(1'b1, 64'h1000, 64'hAA, 8'h01));
      exp_q.push_back(mk(1'b0, 64'h8000_0200, '0, '0));
      instr_rd_en_i = 1'b1; pc_i = 64'h8000_0200;
      mem_wr_en_i = 1'b1; addr_mem_wr_i = 64'h1000; data_mem_wr_i = 64'hAA; strb_mem_wr_i = 8'h01;
      #1;
      for (int c = 0; c < 25; c++) begin
         if (c > 0) step();
         if (!first_req && bus_req_o === 1'b1) begin
            first_req = 1'b1;
            checks++;
            if (bus_we_o !== 1'b1 || bus_addr_o !== 64'h1000) begin
               failures++;
               $display("FAIL store_first got we=%b addr=%h required 1 0000000000001000", bus_we_o, bus_addr_o);
            end
         end
         if (mem_wr_en_i && !stall_mem_o) begin
            wr_cyc = c;
            mem_wr_en_i = 1'b0;
         end
         if (instr_rd_en_i && !stall_if_o) begin
            if_cyc = c;
            instr_rd_en_i = 1'b0;
            checks++;
            if (instr_o !== 32'h0000_0213 || addr_instr_o !== 64'h8000_0200) begin
               failures++;
               $display("FAIL store_fetch_data got instr=%h addr=%h required 00000213 0000000080000200", instr_o, addr_instr_o);
            end
            break;
         end
      end
      checks++;
      if (wr_cyc !== 3 || if_cyc !== 6) begin
         failures++;
         $display("FAIL store_order got wr_done_cycle=%0d if_done_cycle=%0d required 3 6", wr_cyc, if_cyc);
      end
      repeat (3) step();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL store_pending got %0d outstanding required 0", exp_q.size());
      end
   endtask

   task automatic test_stale_fetch();
      int done_cyc;
      done_cyc = -1;
      rsp_wait = 1;
      exp_q.push_back(mk(1'b0, 64'h8000_0000, '0, '0));
      exp_q.push_back(mk(1'b0, 64'h8000_0100, '0, '0));
      instr_rd_en_i = 1'b1; pc_i = 64'h8000_0000;
      #1;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) step();
         if (c == 2) pc_i = 64'h8000_0100;
         if (c == 4) begin
            checks++;
            if (instr_o !== 32'h0000_0213) begin
               failures++;
               $display("FAIL stale_discard got instr=%h required 00000213", instr_o);
            end
         end
         if (stall_if_o !== 1'b1) begin
            done_cyc = c;
            break;
         end
      end
      checks++;
      if (done_cyc !== 8) begin
         failures++;
         $display("FAIL stale_done_cycle got %0d required 8", done_cyc);
      end
      checks++;
      if (instr_o !== 32'h0000_0113 || addr_instr_o !== 64'h8000_0100) begin
         failures++;
         $display("FAIL stale_refetch got instr=%h addr=%h required 00000113 0000000080000100", instr_o, addr_instr_o);
      end
      instr_rd_en_i = 1'b0;
      rsp_wait = 0;
      step();
   endtask

   task automatic test_gnt_backpressure();
      int done_cyc;
      logic [63:0] exp_d;
      done_cyc = -1;
      exp_d = rsp_of(rsp_base, 64'h2000);
      gnt_delay = 10;
      exp_q.push_back(mk(1'b0, 64'h2000, '0, '0));
      mem_rd_en_i = 1'b1; addr_mem_rd_i = 64'h2000;
      #1;
      for (int c = 1; c <= 10; c++) begin
         step();
         checks++;
         if (bus_req_o !== 1'b1 || bus_addr_o !== 64'h2000 || bus_we_o !== 1'b0 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL gnt_hold cycle %0d got req=%b addr=%h we=%b err=%b required 1 0000000000002000 0 0",
                     c, bus_req_o, bus_addr_o, bus_we_o, err_o);
         end
      end
      for (int c = 11; c < 30; c++) begin
         step();
         if (stall_mem_o !== 1'b1) begin
            done_cyc = c;
            break;
         end
      end
      checks++;
      if (done_cyc !== 13 || data_mem_o !== exp_d || err_o !== 1'b0) begin
         failures++;
         $display("FAIL gnt_load got cycle=%0d data=%h err=%b required 13 %h 0", done_cyc, data_mem_o, err_o, exp_d);
      end
      mem_rd_en_i = 1'b0;
      gnt_delay = 0;
      step();
   endtask

   task automatic test_watchdog();
      exp_q.push_back(mk(1'b0, 64'h3000, '0, '0));
      rsp_wait = -1;
      mem_rd_en_i = 1'b1; addr_mem_rd_i = 64'h3000;
      #1;
      for (int c = 0; c <= 6; c++) begin
         if (c > 0) step();
         checks++;
         if (err_o !== (c == 6) || stall_mem_o !== (c < 6)) begin
            failures++;
            $display("FAIL wdt_cycle %0d got err=%b stall=%b required %b %b", c, err_o, stall_mem_o, (c == 6), (c < 6));
         end
      end
      checks++;
      if (data_mem_o !== '0) begin
         failures++;
         $display("FAIL wdt_data got %h required 0", data_mem_o);
      end
      mem_rd_en_i = 1'b0;
      step();
      checks++;
      if (err_o !== 1'b0 || bus_req_o !== 1'b0) begin
         failures++;
         $display("FAIL wdt_idle got err=%b req=%b required 0 0", err_o, bus_req_o);
      end
      pending = 1'b0;
      rsp_wait = 0;
      step();
   endtask

   task automatic test_bus_err();
      exp_q.push_back(mk(1'b1, 64'h1008, 64'h55, 8'h02));
      rsp_err = 1'b1;
      mem_wr_en_i = 1'b1; addr_mem_wr_i = 64'h1008; data_mem_wr_i = 64'h55; strb_mem_wr_i = 8'h02;
      #1;
      for (int c = 0; c <= 4; c++) begin
         if (c > 0) step();
         checks++;
         if (err_o !== (c == 3) || stall_mem_o !== (c < 3 && mem_wr_en_i)) begin
            failures++;
            $display("FAIL bus_err cycle %0d got err=%b stall=%b required %b %b", c, err_o, stall_mem_o, (c == 3), (c < 3));
         end
         if (c == 3) mem_wr_en_i = 1'b0;
      end
      rsp_err = 1'b0;
   endtask

   task automatic test_reset_mid();
      int done_cyc;
      done_cyc = -1;
      rsp_wait = 2;
      exp_q.push_back(mk(1'b0, 64'h8000_0400, '0, '0));
      instr_rd_en_i = 1'b1; pc_i = 64'h8000_0400;
      step();
      step();
      rst = 1'b1;
      instr_rd_en_i = 1'b0;
      step();
      checks++;
      if (bus_req_o !== 1'b0 || bus_addr_o !== '0 || instr_o !== '0 || addr_instr_o !== '0 ||
          data_mem_o !== '0 || err_o !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_values got req=%b baddr=%h instr=%h ainstr=%h data=%h err=%b required all 0",
                  bus_req_o, bus_addr_o, instr_o, addr_instr_o, data_mem_o, err_o);
      end
      rst = 1'b0;
      step();
      rsp_wait = 0;
      exp_q.push_back(mk(1'b0, 64'h8000_0400, '0, '0));
      instr_rd_en_i = 1'b1;
      step();
      checks++;
      if (stall_if_o !== 1'b1 || instr_o !== '0 || addr_instr_o !== '0 || err_o !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_ignore got stall=%b instr=%h ainstr=%h err=%b required 1 0 0 0",
                  stall_if_o, instr_o, addr_instr_o, err_o);
      end
      for (int c = 0; c < 10; c++) begin
         step();
         if (stall_if_o !== 1'b1) begin
            done_cyc = c;
            break;
         end
      end
      checks++;
      if (done_cyc < 0 || instr_o !== 32'h0000_0413 || addr_instr_o !== 64'h8000_0400) begin
         failures++;
         $display("FAIL rst_mid_refetch got cycle=%0d instr=%h addr=%h required done 00000413 0000000080000400",
                  done_cyc, instr_o, addr_instr_o);
      end
      instr_rd_en_i = 1'b0;
      repeat (2) step();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store_priority();
      test_stale_fetch();
      test_gnt_backpressure();
      test_watchdog();
      test_bus_err();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL final_scoreboard got %0d outstanding required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
